// File: rtl/rueckschreib_puffer_pkg.sv
// Shared widths and types for the writeback stage in front of the 64x32 register file.
// Rev 1.0
`default_nettype none

package rueckschreib_puffer_pkg;

  localparam int REG_ANZAHL     = 64;
  localparam int REG_ADR_BREITE = $clog2(REG_ANZAHL);
  localparam int DATEN_BREITE   = 32;

  typedef struct packed {
    logic [REG_ADR_BREITE-1:0] adr;
    logic [DATEN_BREITE-1:0]   daten;
  } eintrag_t;

  typedef enum logic [1:0] {
    QUELLE_KEINE = 2'd0,
    QUELLE_ALU   = 2'd1,
    QUELLE_FIFO  = 2'd2
  } quelle_t;

  // Register 0 is hardwired; writes to it are dropped at the inputs.
  function automatic logic ist_null(input logic [REG_ADR_BREITE-1:0] adr);
    return adr == '0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rueckschreib_fifo.sv
// Synchronous load-result FIFO with occupancy count and two parallel register-match ports.
// Rev 1.0
`default_nettype none

module rueckschreib_fifo
  import rueckschreib_puffer_pkg::*;
#(
  parameter int TIEFE = 4
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      push,
  input  eintrag_t                  push_eintrag,
  input  logic                      pop,
  output eintrag_t                  kopf,
  output logic [$clog2(TIEFE):0]    anzahl,
  input  logic [REG_ADR_BREITE-1:0] such_adr1,
  input  logic [REG_ADR_BREITE-1:0] such_adr2,
  output logic                      treffer1,
  output logic                      treffer2
);

  localparam int ZW = $clog2(TIEFE);

  eintrag_t          speicher [TIEFE];
  logic [ZW-1:0]     lese_zgr;
  logic [ZW-1:0]     schreib_zgr;
  logic [ZW:0]       anzahl_r;
  logic [TIEFE-1:0]  gueltig;
  logic [TIEFE-1:0]  t1;
  logic [TIEFE-1:0]  t2;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      lese_zgr    <= '0;
      schreib_zgr <= '0;
      anzahl_r    <= '0;
    end else begin
      if (push) schreib_zgr <= schreib_zgr + 1'b1;
      if (pop)  lese_zgr    <= lese_zgr + 1'b1;
      case ({push, pop})
        2'b10:   anzahl_r <= anzahl_r + 1'b1;
        2'b01:   anzahl_r <= anzahl_r - 1'b1;
        default: anzahl_r <= anzahl_r;
      endcase
    end
  end

  // Payload needs no reset: stale slots are masked by the occupancy window below.
  always_ff @(posedge Clock) begin
    if (push) speicher[schreib_zgr] <= push_eintrag;
  end

  for (genvar i = 0; i < TIEFE; i++) begin : g_eintrag
    logic [ZW-1:0] abstand;
    assign abstand    = ZW'(i) - lese_zgr;
    assign gueltig[i] = {1'b0, abstand} < anzahl_r;
    assign t1[i]      = gueltig[i] && (speicher[i].adr == such_adr1);
    assign t2[i]      = gueltig[i] && (speicher[i].adr == such_adr2);
  end

  assign treffer1 = |t1;
  assign treffer2 = |t2;
  assign kopf     = speicher[lese_zgr];
  assign anzahl   = anzahl_r;

endmodule

`default_nettype wire

// File: rtl/rueckschreib_puffer.sv
// Writeback arbiter: merges ALU and buffered load results onto the single register-file write port.
// Rev 1.0
`default_nettype none

module rueckschreib_puffer
  import rueckschreib_puffer_pkg::*;
#(
  parameter int TIEFE      = 4,
  parameter int MAX_WARTEN = 4
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      AluGueltig,
  input  logic [REG_ADR_BREITE-1:0] AluRegister,
  input  logic [DATEN_BREITE-1:0]   AluDaten,
  output logic                      AluBereit,
  input  logic                      LadeGueltig,
  input  logic [REG_ADR_BREITE-1:0] LadeRegister,
  input  logic [DATEN_BREITE-1:0]   LadeDaten,
  output logic                      LadeBereit,
  input  logic [REG_ADR_BREITE-1:0] QuellRegister1,
  input  logic [REG_ADR_BREITE-1:0] QuellRegister2,
  output logic                      Wartend1,
  output logic                      Wartend2,
  output logic [REG_ADR_BREITE-1:0] ZielRegister,
  output logic [DATEN_BREITE-1:0]   ZielDaten,
  output logic                      Schreibsignal,
  output logic                      Leer
);

  localparam int ZW = $clog2(TIEFE);
  localparam int WW = $clog2(MAX_WARTEN + 1);
  localparam logic [ZW:0] VOLL = (ZW + 1)'(TIEFE);

  eintrag_t       kopf;
  logic [ZW:0]    anzahl;
  logic           fifo_leer;
  logic           treffer1;
  logic           treffer2;
  logic           push;
  logic           pop;
  logic           zwang;
  logic           alu_gueltig;
  quelle_t        quelle;
  logic [WW-1:0]  warte;
  logic [WW-1:0]  warte_naechst;

  rueckschreib_fifo #(.TIEFE(TIEFE)) u_fifo (
    .Clock        (Clock),
    .Reset        (Reset),
    .push         (push),
    .push_eintrag ('{adr: LadeRegister, daten: LadeDaten}),
    .pop          (pop),
    .kopf         (kopf),
    .anzahl       (anzahl),
    .such_adr1    (QuellRegister1),
    .such_adr2    (QuellRegister2),
    .treffer1     (treffer1),
    .treffer2     (treffer2)
  );

  assign fifo_leer   = (anzahl == '0);
  assign zwang       = (warte == WW'(MAX_WARTEN));
  assign alu_gueltig = AluGueltig && !ist_null(AluRegister);
  assign AluBereit   = !zwang;
  // No full-bypass: a same-cycle pop does not free a slot for the incoming load.
  assign LadeBereit  = !Reset && (anzahl < VOLL);
  assign push        = LadeGueltig && LadeBereit && !ist_null(LadeRegister);

  always_comb begin
    quelle = QUELLE_KEINE;
    if (zwang)
      quelle = QUELLE_FIFO;
    else if (alu_gueltig)
      quelle = QUELLE_ALU;
    else if (!fifo_leer)
      quelle = QUELLE_FIFO;
  end

  assign pop           = (quelle == QUELLE_FIFO);
  assign warte_naechst = (pop || fifo_leer) ? '0 : warte + 1'b1;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      Schreibsignal <= 1'b0;
      ZielRegister  <= '0;
      ZielDaten     <= '0;
      warte         <= '0;
    end else begin
      warte <= warte_naechst;
      case (quelle)
        QUELLE_ALU: begin
          Schreibsignal <= 1'b1;
          ZielRegister  <= AluRegister;
          ZielDaten     <= AluDaten;
        end
        QUELLE_FIFO: begin
          Schreibsignal <= 1'b1;
          ZielRegister  <= kopf.adr;
          ZielDaten     <= kopf.daten;
        end
        default: Schreibsignal <= 1'b0;
      endcase
    end
  end

  // Same-cycle inputs are deliberately excluded so the flags stay off the input timing path.
  assign Wartend1 = !ist_null(QuellRegister1) &&
                    (treffer1 || (Schreibsignal && ZielRegister == QuellRegister1));
  assign Wartend2 = !ist_null(QuellRegister2) &&
                    (treffer2 || (Schreibsignal && ZielRegister == QuellRegister2));
  assign Leer     = fifo_leer && !Schreibsignal;

endmodule

`default_nettype wire
